// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with its own rotating priority pointer. The search for
//   a grant starts at the pointer and moves upward, wrapping at NUM_REQ. When
//   advance_i is high, the pointer moves to the slot after the granted one.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous, active-high reset (pointer -> 0)
//   req_i      request vector, one bit per requester
//   advance_i  move the pointer past the current grant
//   gnt_o      one-hot grant (all zero when nothing requests)
//   gnt_idx_o  binary index of the granted requester
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               sum;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        sum       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IDX_W'(sum);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (advance_i) begin
            ptr <= (int'(gnt_idx_o) == NUM_REQ - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/stream_xbar.sv
// ----------------------------------------------------------------------------
// stream_xbar
//   Registered NUM_IN x NUM_OUT valid/ready stream crossbar. Each input beat
//   names its destination; each output has a round-robin arbiter and a
//   one-entry output register. Beats with an out-of-range destination are
//   accepted and dropped so a bad index cannot wedge the producer.
//
//   Optional build macro STREAM_XBAR_PKT_LOCK_EN: adds in_last_i/out_last_o
//   and holds an output's grant on one input until that input's last beat.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous, active-high reset
//   in_data_i    per-input payload
//   in_dest_i    per-input destination output index
//   in_valid_i   per-input beat valid
//   in_last_i    per-input end of packet (lock build only)
//   in_ready_o   per-input beat accepted this cycle (combinational)
//   out_data_o   per-output registered payload
//   out_src_o    per-output index of the input that produced the held beat
//   out_valid_o  per-output register holds a beat
//   out_last_o   per-output registered end of packet (lock build only)
//   out_ready_i  per-output consumer accepts the beat
// ----------------------------------------------------------------------------
module stream_xbar #(
    parameter  int NUM_IN     = 4,
    parameter  int NUM_OUT    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int DEST_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    in_data_i,
    input  logic [NUM_IN-1:0][DEST_W-1:0]        in_dest_i,
    input  logic [NUM_IN-1:0]                    in_valid_i,
`ifdef STREAM_XBAR_PKT_LOCK_EN
    input  logic [NUM_IN-1:0]                    in_last_i,
`endif
    output logic [NUM_IN-1:0]                    in_ready_o,
    output logic [NUM_OUT-1:0][DATA_WIDTH-1:0]   out_data_o,
    output logic [NUM_OUT-1:0][SRC_W-1:0]        out_src_o,
    output logic [NUM_OUT-1:0]                   out_valid_o,
`ifdef STREAM_XBAR_PKT_LOCK_EN
    output logic [NUM_OUT-1:0]                   out_last_o,
`endif
    input  logic [NUM_OUT-1:0]                   out_ready_i
);

    logic [NUM_OUT-1:0][NUM_IN-1:0] req;
    logic [NUM_OUT-1:0][NUM_IN-1:0] arb_req;
    logic [NUM_OUT-1:0][NUM_IN-1:0] gnt;
    logic [NUM_OUT-1:0][SRC_W-1:0]  gnt_idx;
    logic [NUM_OUT-1:0]             can_load;
    logic [NUM_OUT-1:0]             xfer;
    logic [NUM_OUT-1:0]             advance;
    logic [NUM_IN-1:0]              dest_oor;

    // Request matrix. With a single output the destination field is ignored.
    always_comb begin
        req      = '0;
        dest_oor = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (NUM_OUT == 1) req[j][i] = in_valid_i[i];
                else              req[j][i] = in_valid_i[i] && (int'(in_dest_i[i]) == j);
            end
            dest_oor[i] = in_valid_i[i] && (NUM_OUT > 1) && (int'(in_dest_i[i]) >= NUM_OUT);
        end
    end

    // A stalled register refuses new beats, so the arbiter's grant is only
    // honoured (and its pointer only moves) when the slot can take a beat.
    always_comb begin
        can_load = '0;
        xfer     = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            can_load[j] = !out_valid_o[j] || out_ready_i[j];
            xfer[j]     = (|gnt[j]) && can_load[j];
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (!rst_i) begin
            for (int i = 0; i < NUM_IN; i++) begin
                in_ready_o[i] = dest_oor[i];
                for (int j = 0; j < NUM_OUT; j++) begin
                    if (gnt[j][i] && can_load[j]) in_ready_o[i] = 1'b1;
                end
            end
        end
    end

`ifdef STREAM_XBAR_PKT_LOCK_EN
    logic [NUM_OUT-1:0]            locked;
    logic [NUM_OUT-1:0][SRC_W-1:0] lock_src;

    // While locked, only the owning input is visible to the arbiter, and the
    // pointer moves only when the packet's last beat transfers.
    always_comb begin
        arb_req = req;
        advance = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (locked[j]) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (int'(lock_src[j]) != i) arb_req[j][i] = 1'b0;
                end
            end
            advance[j] = xfer[j] && in_last_i[gnt_idx[j]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked   <= '0;
            lock_src <= '0;
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (xfer[j]) begin
                    locked[j]   <= !in_last_i[gnt_idx[j]];
                    lock_src[j] <= gnt_idx[j];
                end
            end
        end
    end
`else
    always_comb begin
        arb_req = req;
        advance = xfer;
    end
`endif

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_arb
        rr_arbiter #(
            .NUM_REQ (NUM_IN)
        ) u_arb (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (arb_req[j]),
            .advance_i (advance[j]),
            .gnt_o     (gnt[j]),
            .gnt_idx_o (gnt_idx[j])
        );
    end

    // NOTE: the output slots are a handful of flops, not a memory array, so
    // data and src are reset along with valid to keep outputs deterministic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= '0;
            out_data_o  <= '0;
            out_src_o   <= '0;
`ifdef STREAM_XBAR_PKT_LOCK_EN
            out_last_o  <= '0;
`endif
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (xfer[j]) begin
                    out_valid_o[j] <= 1'b1;
                    out_data_o[j]  <= in_data_i[gnt_idx[j]];
                    out_src_o[j]   <= gnt_idx[j];
`ifdef STREAM_XBAR_PKT_LOCK_EN
                    out_last_o[j]  <= in_last_i[gnt_idx[j]];
`endif
                end else if (out_ready_i[j]) begin
                    // Consumed with nothing to replace it; data/src hold.
                    out_valid_o[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_xbar.sv
// ----------------------------------------------------------------------------
// tb_stream_xbar
//   Directed bench for stream_xbar with NUM_IN=4, NUM_OUT=3, DATA_WIDTH=8.
//   Build with STREAM_XBAR_PKT_LOCK_EN defined to also cover packet locking.
// ----------------------------------------------------------------------------
module tb_stream_xbar;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int DW = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NI-1:0][DW-1:0] in_data;
    logic [NI-1:0][1:0]    in_dest;
    logic [NI-1:0]         in_valid;
    logic [NI-1:0]         in_last;
    logic [NI-1:0]         in_ready;
    logic [NO-1:0][DW-1:0] out_data;
    logic [NO-1:0][1:0]    out_src;
    logic [NO-1:0]         out_valid;
    logic [NO-1:0]         out_last;
    logic [NO-1:0]         out_ready;

    int checks   = 0;
    int failures = 0;

    stream_xbar #(
        .NUM_IN     (NI),
        .NUM_OUT    (NO),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_dest_i   (in_dest),
        .in_valid_i  (in_valid),
`ifdef STREAM_XBAR_PKT_LOCK_EN
        .in_last_i   (in_last),
`endif
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_valid_o (out_valid),
`ifdef STREAM_XBAR_PKT_LOCK_EN
        .out_last_o  (out_last),
`endif
        .out_ready_i (out_ready)
    );

`ifndef STREAM_XBAR_PKT_LOCK_EN
    assign out_last = '0;
`endif

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_data  = '0;
        in_dest  = '0;
        in_last  = '1;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = '1;
        rst       = 1'b1;
        in_valid  = '1;           // requests present, but reset must block them
        tick();
        tick();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL reset_valid got=%b exp=000", out_valid);
        end
        checks++;
        if (out_data !== 24'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=000000", out_data);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b exp=0000", in_ready);
        end
        rst      = 1'b0;
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 3'b000 || out_data !== 24'h0 || out_src !== 6'h0) begin
            failures++;
            $display("FAIL idle_after_reset valid=%b data=%h src=%h exp 000/000000/00",
                     out_valid, out_data, out_src);
        end
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++; $display("FAIL idle_ready got=%b exp=0000", in_ready);
        end
    endtask

    task automatic test_single_route();
        idle_inputs();
        out_ready   = '1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hA5;
        in_dest[0]  = 2'd2;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++; $display("FAIL single_ready got=%b exp=0001", in_ready);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 3'b100 || out_data[2] !== 8'hA5 || out_src[2] !== 2'd0) begin
            failures++;
            $display("FAIL single_route valid=%b data=%h src=%0d exp 100/a5/0",
                     out_valid, out_data[2], out_src[2]);
        end
        tick();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL single_drain got=%b exp=000", out_valid);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_rdy;
        idle_inputs();
        out_ready = '1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b1;
            in_dest[i]  = 2'd1;
            in_data[i]  = 8'h10 + 8'(i);
        end
        for (int c = 0; c < 5; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++; $display("FAIL contend_ready[%0d] got=%b exp=%b", c, in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (out_valid[1] !== 1'b1 || out_src[1] !== 2'(c % 4) ||
                out_data[1] !== 8'h10 + 8'(c % 4)) begin
                failures++;
                $display("FAIL contend_out[%0d] valid=%b src=%0d data=%h exp 1/%0d/%h",
                         c, out_valid[1], out_src[1], out_data[1], c % 4, 8'h10 + 8'(c % 4));
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL contend_drain got=%b exp=000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        out_ready    = 3'b110;
        in_valid[1]  = 1'b1;
        in_data[1]   = 8'h3C;
        in_dest[1]   = 2'd0;
        tick();
        in_valid[1]  = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h3C || out_src[0] !== 2'd1) begin
            failures++;
            $display("FAIL bp_load valid=%b data=%h src=%0d exp 1/3c/1",
                     out_valid[0], out_data[0], out_src[0]);
        end
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h77;
        in_dest[2]  = 2'd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_ready[2] !== 1'b0) begin
                failures++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", c, in_ready[2]);
            end
            tick();
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h3C || out_src[0] !== 2'd1) begin
                failures++;
                $display("FAIL bp_stall_hold[%0d] valid=%b data=%h src=%0d exp 1/3c/1",
                         c, out_valid[0], out_data[0], out_src[0]);
            end
        end
        out_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[2] !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready[2]);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h77 || out_src[0] !== 2'd2) begin
            failures++;
            $display("FAIL bp_reload valid=%b data=%h src=%0d exp 1/77/2",
                     out_valid[0], out_data[0], out_src[0]);
        end
        tick();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL bp_drain got=%b exp=000", out_valid);
        end
    endtask

    task automatic test_parallel_invalid();
        idle_inputs();
        out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b1;
            in_dest[i]  = 2'(i);
            in_data[i]  = 8'h01 + 8'(i);
        end
        #1;
        checks++;
        if (in_ready !== 4'b0111) begin
            failures++; $display("FAIL par_ready got=%b exp=0111", in_ready);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 3'b111 || out_data !== 24'h030201 || out_src !== 6'b10_01_00) begin
            failures++;
            $display("FAIL par_out valid=%b data=%h src=%b exp 111/030201/100100",
                     out_valid, out_data, out_src);
        end
        tick();
        in_valid[3] = 1'b1;
        in_dest[3]  = 2'd3;
        in_data[3]  = 8'hFF;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++; $display("FAIL oor_ready got=%b exp=1000", in_ready);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL oor_dropped got=%b exp=000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        out_ready   = '1;
        in_valid[0] = 1'b1;
        in_dest[0]  = 2'd2;
        for (int c = 0; c < 4; c++) begin
            in_data[0] = 8'h40 + 8'(c);
            tick();
            checks++;
            if (out_valid[2] !== 1'b1 || out_data[2] !== 8'h40 + 8'(c)) begin
                failures++;
                $display("FAIL b2b[%0d] valid=%b data=%h exp 1/%h",
                         c, out_valid[2], out_data[2], 8'h40 + 8'(c));
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL b2b_drain got=%b exp=000", out_valid);
        end
    endtask

`ifdef STREAM_XBAR_PKT_LOCK_EN
    task automatic test_pkt_lock();
        idle_inputs();
        out_ready = '1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid[1] = 1'b1;
        in_dest[1]  = 2'd0;
        in_data[1]  = 8'hC1;
        in_last[1]  = 1'b1;
        in_valid[0] = 1'b1;
        in_dest[0]  = 2'd0;
        for (int b = 0; b < 3; b++) begin
            in_data[0] = 8'hB0 + 8'(b);
            in_last[0] = (b == 2);
            #1;
            checks++;
            if (in_ready !== 4'b0001) begin
                failures++; $display("FAIL lock_ready[%0d] got=%b exp=0001", b, in_ready);
            end
            tick();
            checks++;
            if (out_src[0] !== 2'd0 || out_data[0] !== 8'hB0 + 8'(b) ||
                out_last[0] !== (b == 2)) begin
                failures++;
                $display("FAIL lock_beat[%0d] src=%0d data=%h last=%b exp 0/%h/%0d",
                         b, out_src[0], out_data[0], out_last[0], 8'hB0 + 8'(b), b == 2);
            end
        end
        in_valid[0] = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++; $display("FAIL lock_handoff_ready got=%b exp=0010", in_ready);
        end
        tick();
        checks++;
        if (out_src[0] !== 2'd1 || out_data[0] !== 8'hC1) begin
            failures++;
            $display("FAIL lock_handoff src=%0d data=%h exp 1/c1", out_src[0], out_data[0]);
        end
        // Start a new packet from in0, then reset in the middle of it.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hD0;
        in_last[0]  = 1'b0;
        tick();
        checks++;
        if (out_src[0] !== 2'd0 || out_data[0] !== 8'hD0) begin
            failures++;
            $display("FAIL lock_mid_start src=%0d data=%h exp 0/d0", out_src[0], out_data[0]);
        end
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++; $display("FAIL lock_mid_block got=%b exp=0001", in_ready);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 3'b000 || out_last !== 3'b000) begin
            failures++;
            $display("FAIL lock_reset valid=%b last=%b exp 000/000", out_valid, out_last);
        end
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++; $display("FAIL lock_cleared_ready got=%b exp=0010", in_ready);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid[0] !== 1'b1 || out_src[0] !== 2'd1) begin
            failures++;
            $display("FAIL lock_cleared_out valid=%b src=%0d exp 1/1", out_valid[0], out_src[0]);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        out_ready = '1;
        rst       = 1'b1;
        test_reset();
        test_single_route();
        test_contention();
        test_backpressure();
        test_parallel_invalid();
        test_back_to_back();
`ifdef STREAM_XBAR_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_xbar.md
Name: stream_xbar

Overview:
- Registered, handshaked N-input x M-output stream crossbar. Parametrised successor to the combinational select crossbar.
- Each input beat carries its own destination index.
- Each output has a round-robin arbiter that resolves contention between inputs, and a one-entry output register driving a valid/ready interface.
- Used wherever several producers share several consumers with backpressure.

Parameters:
- NUM_IN, 4, number of input streams (>=1)
- NUM_OUT, 4, number of output streams (>=1)
- DATA_WIDTH, 8, payload width in bits
- Local params: DEST_W = max(1, $clog2(NUM_OUT)); SRC_W = max(1, $clog2(NUM_IN))

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- in_data_i  input  [NUM_IN][DATA_WIDTH]  input payloads
- in_dest_i  input  [NUM_IN][DEST_W]  destination output index per input
- in_valid_i  input  [NUM_IN]  input beat valid
- in_ready_o  output  [NUM_IN]  input beat accepted this cycle (combinational)
- out_data_o  output  [NUM_OUT][DATA_WIDTH]  registered payload
- out_src_o  output  [NUM_OUT][SRC_W]  index of the input that produced the held beat
- out_valid_o  output  [NUM_OUT]  output register holds a beat
- out_ready_i  input  [NUM_OUT]  consumer accepts the beat

Behaviour:
- Reset, synchronous, active-high:
  - out_valid_o=0, out_data_o=0, out_src_o=0, all RR pointers=0.
  - Reset mid-transfer discards every held beat. in_ready_o is 0 while rst_i=1.
- Request: req[j][i] = in_valid_i[i] && (in_dest_i[i]==j).
- Per output j:
  - can_load[j] = !out_valid_o[j] || out_ready_i[j].
  - Arbiter grants exactly one requesting input. Search starts at ptr[j] and proceeds upward, wrapping at NUM_IN.
- in_ready_o[i] = grant[dest(i)][i] && can_load[dest(i)].
  - in_ready_o may depend on in_valid_i/in_dest_i.
  - in_valid_i must not depend on in_ready_o.
- Transfer on input i = in_valid_i[i] && in_ready_o[i]. On transfer to output j:
  - out_data_o[j] <= in_data_i[i]
  - out_src_o[j] <= i
  - out_valid_o[j] <= 1
  - ptr[j] <= (i+1) mod NUM_IN
- If out_ready_i[j] is high, out_valid_o[j] is high, and there is no new transfer: out_valid_o[j] <= 0. Data and src hold their last values.
- Stall: out_valid_o[j]=1 && out_ready_i[j]=0.
  - Register is stable (data, src, valid unchanged).
  - No input destined to j is readied.
  - ptr[j] does not move.
- Latency: 1 cycle from input transfer to out_valid_o.
- Throughput: 1 beat per output per cycle when out_ready_i is held high. All outputs operate in parallel and independently.
- Out-of-range destination (in_dest_i >= NUM_OUT, possible when NUM_OUT is not a power of 2):
  - in_ready_o=1 immediately and the beat is dropped. This avoids deadlock.
- NUM_IN=1: arbiter degenerates to pass-through; ptr stays 0. NUM_OUT=1: in_dest_i is ignored.
- Fairness: with k persistent contenders on one output, each input is served once every k granted beats.

Optional Feature:
- Macro: STREAM_XBAR_PKT_LOCK_EN
- Defined:
  - Adds ports in_last_i [NUM_IN] (input) and out_last_o [NUM_OUT] (output, registered alongside data, reset 0).
  - Once output j grants input i on a beat with in_last_i[i]=0, the grant is locked to i until a beat with in_last_i[i]=1 transfers.
  - While locked, other inputs requesting j get in_ready_o=0.
  - ptr[j] advances only on the last beat.
  - Reset clears the lock.
- Not defined:
  - Ports are absent. Arbitration is per beat as described above.

Decomposition:
- No shared package needed. DEST_W and SRC_W are local params in the module.
- One sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Ports: clk_i, rst_i, req_i, advance_i, gnt_o (one-hot), gnt_idx_o.
  - Holds its own pointer.
  - Instantiated NUM_OUT times.

Test Plan:
1. Reset, then idle: all out_valid_o=0, out_data_o=0, in_ready_o=0 while rst_i=1 → all stay 0 after release with no valid.
2. Single route: in0 data=0xA5, dest=2, out_ready=all 1 → next cycle out_valid_o[2]=1, out_data_o[2]=0xA5, out_src_o[2]=0; other outputs stay invalid.
3. Contention: in0..in3 all dest=1, always valid, out_ready[1]=1 → out_src_o[1] sequence 0,1,2,3,0; one beat per cycle.
4. Backpressure: out_valid_o[0]=1 holding 0x3C, out_ready[0]=0 for 5 cycles with in2 requesting dest 0 → in_ready_o[2]=0, register stable at 0x3C; after ready rises, 0x3C is consumed and in2's beat loads the same cycle.
5. Parallel plus invalid destination, NUM_OUT=3: in0→0, in1→1, in2→2 simultaneously → all three outputs valid next cycle. in3 with dest=3 → in_ready_o[3]=1, nothing appears on any output.
6. With STREAM_XBAR_PKT_LOCK_EN: in0 sends a 3-beat packet to out0 while in1 also requests out0 → in0's 3 beats are contiguous, then in1 is granted; reset asserted mid-packet → lock cleared, out_valid_o=0.
